modmul_issue_collect: RTL
=========================

// Module: modmul_issue_collect
// PURPOSE
//  Requester-side front end for the 256-bit fixed-latency modular multiplier pipeline. Accepts tagged
//  operand pairs over a valid/ready handshake, drives the multiplier's in_valid/Xin/Yin, and captures
//  its Q/out_valid stream. Results are buffered with their tags in a FIFO and presented downstream with
//  backpressure. Credit-based issue guarantees no result is ever lost, since the multiplier cannot stall.
// PARAMETERS
//  WIDTH      256  operand/result width in bits
//  TAG_W      4    user tag width; tags are returned in issue order
//  DEPTH      32   result FIFO and tag FIFO depth (power of 2); also the total credit count
//  TIMEOUT    64   cycles without mul_out_valid while outstanding>0 before timeout_err is set
// PORTS
//  clock          in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high reset
//  s_valid        in   1        upstream operand pair valid
//  s_ready        out  1        block can accept an operand pair
//  s_x            in   WIDTH    operand X
//  s_y            in   WIDTH    operand Y
//  s_tag          in   TAG_W    request tag
//  mul_in_valid   out  1        to multiplier in_valid
//  mul_x          out  WIDTH    to multiplier Xin
//  mul_y          out  WIDTH    to multiplier Yin
//  mul_q          in   WIDTH    from multiplier Q
//  mul_out_valid  in   1        from multiplier out_valid
//  m_valid        out  1        result available downstream
//  m_ready        in   1        downstream accepts result
//  m_q            out  WIDTH    result
//  m_tag          out  TAG_W    tag of the request that produced m_q
//  outstanding    out  log2(DEPTH)+1  issued requests whose results have not yet arrived from the multiplier
//  spurious_err   out  1        sticky: mul_out_valid arrived with no outstanding tag
//  timeout_err    out  1        sticky: watchdog expired
//  err_clear      in   1        synchronous clear of both sticky error flags
// BEHAVIOUR
//  Reset (async): credits=DEPTH; outstanding=0; both FIFOs empty; mul_in_valid=0; mul_x=mul_y=0;
//   m_valid=0; m_q=0; m_tag=0; spurious_err=0; timeout_err=0; watchdog=0. s_ready is low while reset is asserted.
//  Issue: s_ready = (credits!=0). When s_valid&&s_ready at edge N, mul_in_valid=1 with
//   mul_x=s_x, mul_y=s_y registered in cycle N+1 (single cycle). s_tag is pushed to the tag FIFO at
//   edge N. Otherwise mul_in_valid=0 and mul_x/mul_y hold their values. Back-to-back issue every cycle is allowed.
//  Credits: credits_next = credits - issue + (m_valid&&m_ready). An issue and a pop in the same cycle leave
//   credits unchanged. Invariant: credits + outstanding + result_fifo_count == DEPTH.
//  Collect: on mul_out_valid with the tag FIFO non-empty, pop the tag FIFO and push {tag, mul_q} into the
//   result FIFO. Credits guarantee space, so there is no overflow check on this path.
//   On mul_out_valid with the tag FIFO empty: discard the data, set spurious_err, and leave all counters unchanged.
//  outstanding = tag FIFO count; it takes +1 on issue and -1 on a collect, and both in the same cycle net to 0.
//  Downstream: the result FIFO is first-word-fall-through. m_valid = !empty; m_q/m_tag show the head entry.
//   A pop occurs on m_valid&&m_ready. Once m_valid rises, it and the data stay stable until accepted.
//   A push into an empty FIFO makes m_valid high on the next cycle. Push and pop in the same cycle are legal at any
//   occupancy, including full (pop frees the slot) and empty+push (no pop, since m_valid was 0).
//  Ordering: results leave in issue order because the multiplier is in-order and fixed-latency.
//  Watchdog: counts cycles where outstanding!=0 and mul_out_valid==0. It clears on mul_out_valid or when outstanding==0.
//   When it reaches TIMEOUT, timeout_err is set and the counter saturates.
//  err_clear clears both flags. If a new error event occurs in the same cycle, the event wins (flag set).
//  Multiplier shares this reset. After a reset, any pre-reset results still in flight are treated as
//   spurious (dropped, flagged). Reset mid-operation discards all buffered results and tags.
// TESTING
//  1 req X=3,Y=5,tag=0x2, model mult latency 25 -> mul_in_valid 1 cycle after accept; m_valid with m_q=model,m_tag=0x2
//  32 back-to-back reqs, m_ready=0 -> s_ready drops after the 32nd accept; all 32 arrive; the 33rd is held until a pop
//  Full FIFO, m_ready=1 with s_valid=1 each cycle -> sustained 1 result/cycle, credits stay 0, tags in order 0..15 wrap
//  Inject mul_out_valid with nothing issued -> spurious_err=1, m_valid stays 0; err_clear -> 0
//  Issue 1 req, suppress mul_out_valid 64 cycles -> timeout_err=1 at cycle 64; the late result is still collected
//  Assert reset with 10 outstanding and 5 buffered -> all outputs at reset values immediately; stray results flag spurious_err

Source files
------------

// File: rtl/modmul_fifo.sv
// Generic first-word-fall-through FIFO: head_dat always shows the oldest entry.
// Latency: a push is visible at head_dat/count one cycle later; a pop frees its slot the same edge.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module modmul_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; push and pop together keep count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_rdy) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/modmul_issue_collect.sv
// Credit-based issue/collect front end for the non-stallable fixed-latency modular multiplier.
// Latency: accept -> mul_in_valid next cycle; mul_out_valid -> m_valid next cycle (FWFT result buffer).
// Backpressure: s_ready drops when all DEPTH credits are in flight or buffered; m_ready only stalls the result buffer.
module modmul_issue_collect #(
    parameter int WIDTH   = 256,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_x,
    input  logic [WIDTH-1:0]       s_y,
    input  logic [TAG_W-1:0]       s_tag,
    output logic                   mul_in_valid,
    output logic [WIDTH-1:0]       mul_x,
    output logic [WIDTH-1:0]       mul_y,
    input  logic [WIDTH-1:0]       mul_q,
    input  logic                   mul_out_valid,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_q,
    output logic [TAG_W-1:0]       m_tag,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   spurious_err,
    output logic                   timeout_err,
    input  logic                   err_clear
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] q;
    } res_t;

    logic [CW-1:0]    credits;
    logic             issue_vld;
    logic             pop_vld;
    logic             collect_vld;
    logic             spurious_evt;
    logic             wd_run;
    logic             timeout_evt;
    logic [WDW-1:0]   wd_cnt;
    logic [TAG_W-1:0] tag_head_dat;
    logic [CW-1:0]    res_count;
    logic             res_empty;
    res_t             res_push_dat;
    res_t             res_head_dat;

    // Held low during reset even though the credit register already shows DEPTH.
    assign s_ready      = !reset && (credits != '0);
    assign issue_vld    = s_valid && s_ready;
    assign res_empty    = (res_count == '0);
    assign m_valid      = !res_empty;
    assign pop_vld      = m_valid && m_ready;
    // A result with no tag waiting is a stray (e.g. in flight across a reset) and is dropped.
    assign collect_vld  = mul_out_valid && (outstanding != '0);
    assign spurious_evt = mul_out_valid && (outstanding == '0);
    assign wd_run       = (outstanding != '0) && !mul_out_valid;
    assign timeout_evt  = wd_run && (wd_cnt == WDW'(TIMEOUT - 1));
    assign res_push_dat = '{tag: tag_head_dat, q: mul_q};
    // Outputs read zero while the buffer is empty so stale storage never leaks out.
    assign m_q          = res_empty ? '0 : res_head_dat.q;
    assign m_tag        = res_empty ? '0 : res_head_dat.tag;

    // Tags of issued requests; occupancy is the in-flight count.
    modmul_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (issue_vld),
        .push_dat (s_tag),
        .pop_rdy  (collect_vld),
        .head_dat (tag_head_dat),
        .count    (outstanding)
    );

    // Collected results awaiting the downstream consumer; credits guarantee space.
    modmul_fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (collect_vld),
        .push_dat (res_push_dat),
        .pop_rdy  (pop_vld),
        .head_dat (res_head_dat),
        .count    (res_count)
    );

    // One credit per result slot: consumed on issue, returned when downstream takes a result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits <= CW'(DEPTH);
        end else begin
            case ({issue_vld, pop_vld})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Single-cycle issue pulse; operands hold their last value between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_in_valid <= 1'b0;
            mul_x        <= '0;
            mul_y        <= '0;
        end else begin
            mul_in_valid <= issue_vld;
            if (issue_vld) begin
                mul_x <= s_x;
                mul_y <= s_y;
            end
        end
    end

    // Watchdog: counts silent cycles with work in flight, saturating at TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (!wd_run) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WDW'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spurious_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (spurious_evt) begin
                spurious_err <= 1'b1;
            end else if (err_clear) begin
                spurious_err <= 1'b0;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (err_clear) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
